uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

  // 100 MHz system clock at 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT = 32'd868;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-value selection for the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre and reports either a
// one-cycle data-valid pulse with the byte or a one-cycle framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk_in1,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] data_out,
  output logic       DV_1,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rx_s;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             armed_q, armed_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk_in1),
    .rst_n (rst),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Frame sequencing and output pulse generation.
  // armed_q: line has been seen high since the last stop bit began, so a low
  // level in IDLE is a genuine start and a break cannot retrigger reception.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = armed_q | rx_s;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (armed_q && !rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            armed_d = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
          if (rx_s) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
    end
  end

  assign data_out  = data_q;
  assign DV_1      = dv_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule
